// File: rtl/matrix_exec_sequencer.sv
// matrix_exec_sequencer: fetches 9-bit instructions {opcode, control, addr},
// moves matrix operands from RAM onto the ALU bus, issues compute commands and
// writes OUT results back to RAM.
// Optional busy-cycle counter: define SEQ_PERF_CNT_EN to build perf_cycles.
module matrix_exec_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned ALU_LATENCY = 2,
  parameter int unsigned DATA_W      = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [8:0]        instr_data,
  output logic [2:0]        mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        op_code,
  output logic [2:0]        ALU_control,
  output logic              nALU_Enable,
  output logic [DATA_W-1:0] alu_data_out,
  output logic              alu_data_oe,
  input  logic [DATA_W-1:0] alu_data_in,
  output logic [31:0]       perf_cycles
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] CTL_OUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LDRV, S_EXEC, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       instr_q, instr_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // State and datapath registers; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, program counter and latency countdown
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = instr_data;
        case (instr_data[8:6])
          OP_NOP: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
          OP_LOAD: state_d = S_LDRV;
          OP_HALT: state_d = S_DONE;
          default: state_d = S_EXEC;
        endcase
      end
      S_LDRV: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_EXEC: begin
        if (instr_q[5:3] == CTL_OUT) begin
          state_d = S_WAIT;
          wait_d  = CNT_W'(ALU_LATENCY - 1);
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_WB;
        else              wait_d  = wait_q - CNT_W'(1);
      end
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and memory strobes decoded from the current state
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    instr_addr   = pc_q;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    op_code      = OP_NOP;
    ALU_control  = '0;
    nALU_Enable  = 1'b1;
    alu_data_out = '0;
    alu_data_oe  = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (instr_data[8:6] == OP_LOAD) begin
          mem_rd   = 1'b1;
          mem_addr = instr_data[2:0];
        end
      end
      S_LDRV: begin
        alu_data_out = mem_rdata;
        alu_data_oe  = 1'b1;
        op_code      = OP_LOAD;
        ALU_control  = instr_q[5:3];
        nALU_Enable  = 1'b0;
      end
      S_EXEC: begin
        op_code     = instr_q[8:6];
        ALU_control = instr_q[5:3];
        nALU_Enable = 1'b0;
      end
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = instr_q[2:0];
        mem_wdata = alu_data_in;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  // Busy-cycle counter: clears on start acceptance, saturates, holds in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) perf_q <= '0;
    end else if (perf_q != '1) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_matrix_exec_sequencer.sv
// Self-checking bench for matrix_exec_sequencer: directed program, reset abort,
// latency/wrap checks on a small instance, and random programs checked
// against an instruction-level interpreter with a 4x4 matrix-multiply ALU.
module tb_matrix_exec_sequencer;

  localparam int LAT_A = 2;
  localparam int LAT_B = 5;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif
  localparam logic [255:0] RAM0 =
    256'h0005_0008_0006_0002_0007_0003_0008_0004_0006_0005_0001_0003_0008_0005_0007_0009;
  localparam logic [255:0] RAM1 =
    256'h000b_000e_0013_0012_0006_0009_0004_0005_000c_000a_000f_000e_0006_0003_0008_0007;
  localparam logic [8:0] HALT = 9'b111_000_000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: default parameters
  logic a_start, a_busy, a_done, a_mrd, a_mwr, a_nen, a_oe;
  logic [7:0] a_iaddr;
  logic [8:0] a_idata;
  logic [2:0] a_maddr, a_op, a_ctl;
  logic [255:0] a_mrdata, a_mwdata, a_dout, a_din;
  logic [31:0] a_perf;

  matrix_exec_sequencer dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .instr_addr(a_iaddr), .instr_data(a_idata), .mem_addr(a_maddr), .mem_rd(a_mrd),
    .mem_rdata(a_mrdata), .mem_wr(a_mwr), .mem_wdata(a_mwdata), .op_code(a_op),
    .ALU_control(a_ctl), .nALU_Enable(a_nen), .alu_data_out(a_dout),
    .alu_data_oe(a_oe), .alu_data_in(a_din), .perf_cycles(a_perf)
  );

  // Instance B: 4-entry program space, long ALU latency
  logic b_start, b_busy, b_done, b_mrd, b_mwr, b_nen, b_oe;
  logic [1:0] b_iaddr;
  logic [8:0] b_idata;
  logic [2:0] b_maddr, b_op, b_ctl;
  logic [255:0] b_mrdata, b_mwdata, b_dout, b_din;
  logic [31:0] b_perf;

  matrix_exec_sequencer #(.PC_W(2), .ALU_LATENCY(LAT_B), .DATA_W(256)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .instr_addr(b_iaddr), .instr_data(b_idata), .mem_addr(b_maddr), .mem_rd(b_mrd),
    .mem_rdata(b_mrdata), .mem_wr(b_mwr), .mem_wdata(b_mwdata), .op_code(b_op),
    .ALU_control(b_ctl), .nALU_Enable(b_nen), .alu_data_out(b_dout),
    .alu_data_oe(b_oe), .alu_data_in(b_din), .perf_cycles(b_perf)
  );

  function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
    return m[255-16*(4*r+c) -: 16];
  endfunction

  function automatic logic [255:0] matmul(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] res;
    logic [15:0] s;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int k = 0; k < 4; k++) s = s + el(x, r, k) * el(y, k, c);
        res[255-16*(4*r+c) -: 16] = s;
      end
    return res;
  endfunction

  // Memories and ALU model for instance A
  logic [8:0]   rom_a [256];
  logic [8:0]   rom_b [4];
  logic [255:0] ram_a [8];
  logic [255:0] ram_init [8];
  logic [255:0] m_ram [8];
  logic         ram_load = 1'b0;
  int           a_wr_cnt = 0;
  logic [2:0]   a_wr_slot = '0;
  logic [255:0] a_wr_data = '0;
  int           cyc = 0;
  int           alu_ready = 32'h7fff_ffff;
  logic [255:0] alu_ra = '0, alu_rb = '0, alu_res = '0;

  always @(posedge clk) a_idata <= rom_a[a_iaddr];
  always @(posedge clk) b_idata <= rom_b[b_iaddr];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) ram_a[i] <= ram_init[i];
    end else begin
      if (a_mrd) a_mrdata <= ram_a[a_maddr];
      if (a_mwr) begin
        ram_a[a_maddr] <= a_mwdata;
        a_wr_cnt       <= a_wr_cnt + 1;
        a_wr_slot      <= a_maddr;
        a_wr_data      <= a_mwdata;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!a_nen) begin
      if (a_op == 3'b001) begin
        if (a_ctl == 3'b001) alu_ra <= a_dout;
        else if (a_ctl == 3'b100) alu_rb <= a_dout;
      end else begin
        alu_res   <= (a_op == 3'b101) ? matmul(alu_ra, alu_rb) : '0;
        alu_ready <= cyc + LAT_A;
      end
    end
  end

  assign a_din = (cyc >= alu_ready) ? alu_res : {16{16'hdead}};

  // Bus-protocol invariants on both instances
  int viol = 0;
  int b_wr_seen = 0;
  always @(negedge clk) begin
    if (a_mrd && a_mwr) viol <= viol + 1;
    else if (a_oe && !a_nen && a_op != 3'b001) viol <= viol + 1;
    else if (b_mrd && b_mwr) viol <= viol + 1;
    else if (b_oe && !b_nen && b_op != 3'b001) viol <= viol + 1;
    if (b_mwr) b_wr_seen <= b_wr_seen + 1;
  end

  // Per-cycle trace of the first cycles of a run
  logic [7:0] tr_iaddr [16];
  logic [2:0] tr_op [16], tr_ctl [16], tr_maddr [16];
  logic       tr_nen [16], tr_oe [16], tr_mrd [16];
  logic [255:0] tr_dout [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ram();
    @(negedge clk); ram_load = 1'b1;
    @(negedge clk); ram_load = 1'b0;
  endtask

  task automatic run_a(input int budget, input int mid_start,
                       output int busy_n, output int done_n, output int done_at, output bit fin);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; fin = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!a_busy) begin fin = 1'b1; break; end
      busy_n++;
      if (a_done) begin done_n++; done_at = i; end
      if (i < 16) begin
        tr_iaddr[i] = a_iaddr; tr_op[i] = a_op; tr_ctl[i] = a_ctl; tr_nen[i] = a_nen;
        tr_oe[i] = a_oe; tr_mrd[i] = a_mrd; tr_maddr[i] = a_maddr; tr_dout[i] = a_dout;
      end
      a_start = (i == mid_start);
      @(negedge clk);
    end
    a_start = 1'b0;
  endtask

  task automatic run_b(input int budget,
                       output int busy_n, output int done_n, output int done_at, output bit fin);
    b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; fin = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!b_busy) begin fin = 1'b1; break; end
      busy_n++;
      if (b_done) begin done_n++; done_at = i; end
      if (i < 16) begin
        tr_iaddr[i] = 8'(b_iaddr); tr_op[i] = b_op; tr_ctl[i] = b_ctl;
        tr_nen[i] = b_nen; tr_oe[i] = b_oe;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk(tag, 256'({a_busy, a_done, a_iaddr, a_maddr, a_mrd, a_mwr, a_op, a_ctl, a_nen, a_oe, a_perf}),
        256'({1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 32'd0}));
    chk({tag, "_buses"}, {a_mwdata[127:0], a_dout[127:0]}, '0);
  endtask

  // Instruction-level interpreter of the program in rom_a over ram_init
  task automatic model_run(output int cost, output int wr_n);
    logic [255:0] ma, mb;
    logic [8:0] ins;
    int pc;
    ma = '0; mb = '0; cost = 0; wr_n = 0; pc = 0;
    for (int i = 0; i < 8; i++) m_ram[i] = ram_init[i];
    for (int step = 0; step < 300; step++) begin
      ins = rom_a[pc];
      if (ins[8:6] == 3'b111) begin cost += 3; break; end
      else if (ins[8:6] == 3'b000) cost += 2;
      else if (ins[8:6] == 3'b001) begin
        cost += 3;
        if (ins[5:3] == 3'b001) ma = m_ram[ins[2:0]];
        else if (ins[5:3] == 3'b100) mb = m_ram[ins[2:0]];
      end else if (ins[5:3] == 3'b111) begin
        cost += 4 + LAT_A;
        m_ram[ins[2:0]] = (ins[8:6] == 3'b101) ? matmul(ma, mb) : '0;
        wr_n++;
      end else cost += 3;
      pc = (pc + 1) % 256;
    end
  endtask

  task automatic gen_prog(output int len);
    int n;
    logic [8:0] ins;
    for (int i = 0; i < 256; i++) rom_a[i] = HALT;
    rom_a[0] = {3'b001, 3'b001, 3'($urandom_range(0, 7))};
    rom_a[1] = {3'b001, 3'b100, 3'($urandom_range(0, 7))};
    rom_a[2] = {3'b101, 3'b111, 3'($urandom_range(0, 7))};
    n = $urandom_range(3, 8);
    for (int j = 0; j < n; j++) begin
      case ($urandom_range(0, 3))
        0: ins = {3'b000, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        1: ins = {3'b001, ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b100, 3'($urandom_range(0, 7))};
        2: ins = {3'($urandom_range(2, 6)), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 7))};
        default: ins = {3'b101, 3'b111, 3'($urandom_range(0, 7))};
      endcase
      rom_a[3+j] = ins;
    end
    len = n + 4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, done_at, wr0, cost, wr_n, len, acc_busy, acc_wr;
    bit fin;
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0;
    b_mrdata = '0; b_din = '0;
    for (int i = 0; i < 256; i++) rom_a[i] = HALT;
    for (int i = 0; i < 4; i++) rom_b[i] = HALT;
    for (int i = 0; i < 8; i++) ram_init[i] = 256'(i) * 256'h1_0001;
    ram_init[0] = RAM0; ram_init[1] = RAM1;
    load_ram();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_a("reset_a");
    chk("reset_b", 256'({b_busy, b_done, b_iaddr, b_mrd, b_mwr, b_nen, b_oe, b_perf}),
        256'({1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0}));

    // Directed program with a start pulse mid-run
    rom_a[0] = 9'b001_001_000; rom_a[1] = 9'b001_100_001;
    rom_a[2] = 9'b101_111_010; rom_a[3] = HALT;
    wr0 = a_wr_cnt;
    run_a(100, 5, busy_n, done_n, done_at, fin);
    chk("dir_finished", 256'(fin), 256'(1));
    chk("dir_busy_cycles", 256'(busy_n), 256'(15));
    chk("dir_done_pulses", 256'(done_n), 256'(1));
    chk("dir_done_at", 256'(done_at), 256'(14));
    chk("dir_wr_count", 256'(a_wr_cnt - wr0), 256'(1));
    chk("dir_wr_slot", 256'(a_wr_slot), 256'(2));
    chk("dir_elem00", 256'(a_wr_data[255 -: 16]), 256'(16'h00bb));
    chk("dir_elem01", 256'(a_wr_data[239 -: 16]), 256'(16'h00d0));
    chk("dir_wr_data", a_wr_data, matmul(RAM0, RAM1));
    chk("dir_perf", 256'(a_perf), PERF_ON ? 256'(15) : 256'(0));
    chk("dir_fetch_addr", 256'(tr_iaddr[0]), 256'(0));
    chk("dir_decode_rd", 256'({tr_mrd[1], tr_maddr[1]}), 256'({1'b1, 3'd0}));
    chk("dir_ldrv_ctl", 256'({tr_op[2], tr_ctl[2], tr_nen[2], tr_oe[2]}),
        256'({3'b001, 3'b001, 1'b0, 1'b1}));
    chk("dir_ldrv_data", tr_dout[2], RAM0);
    chk("dir_after_ldrv", 256'({tr_nen[3], tr_oe[3]}), 256'({1'b1, 1'b0}));

    // Reset during the first WAIT cycle drops the pending write-back
    ram_init[2] = {8{32'h5a5a_a5a5}};
    load_ram();
    wr0 = a_wr_cnt;
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk_reset_a("rst_abort");
    acc_busy = 0; acc_wr = 0;
    for (int i = 0; i < 6; i++) begin
      acc_busy += int'(a_busy); acc_wr += int'(a_mwr);
      @(negedge clk);
    end
    chk("rst_busy_low", 256'(acc_busy), 256'(0));
    chk("rst_no_wr", 256'(acc_wr + a_wr_cnt - wr0), 256'(0));
    chk("rst_slot2_kept", ram_a[2], {8{32'h5a5a_a5a5}});

    // Random programs against the interpreter
    for (int t = 0; t < 5; t++) begin
      gen_prog(len);
      for (int i = 0; i < 8; i++)
        for (int w = 0; w < 8; w++) ram_init[i][w*32 +: 32] = $urandom();
      load_ram();
      model_run(cost, wr_n);
      wr0 = a_wr_cnt;
      run_a(400, -1, busy_n, done_n, done_at, fin);
      chk($sformatf("rnd%0d_finished", t), 256'(fin), 256'(1));
      chk($sformatf("rnd%0d_busy_cycles", t), 256'(busy_n), 256'(cost));
      chk($sformatf("rnd%0d_done", t), 256'({done_n, done_at}), 256'({32'd1, 32'(cost - 1)}));
      chk($sformatf("rnd%0d_wr_count", t), 256'(a_wr_cnt - wr0), 256'(wr_n));
      chk($sformatf("rnd%0d_perf", t), 256'(a_perf), PERF_ON ? 256'(cost) : 256'(0));
      for (int i = 0; i < 8; i++) chk($sformatf("rnd%0d_ram%0d", t, i), ram_a[i], m_ram[i]);
    end

    // Long latency, compute without OUT, then NOP and HALT
    rom_b[0] = 9'b101_000_011; rom_b[1] = 9'b000_000_000; rom_b[2] = HALT; rom_b[3] = HALT;
    @(negedge clk);
    run_b(100, busy_n, done_n, done_at, fin);
    chk("lat5_finished", 256'(fin), 256'(1));
    chk("lat5_busy_cycles", 256'(busy_n), 256'(8));
    chk("lat5_done_at", 256'({done_n, done_at}), 256'({32'd1, 32'd7}));
    chk("lat5_exec_ctl", 256'({tr_op[2], tr_ctl[2], tr_nen[2], tr_oe[2]}),
        256'({3'b101, 3'b000, 1'b0, 1'b0}));
    chk("lat5_after_exec", 256'({tr_op[3], tr_nen[3]}), 256'({3'b000, 1'b1}));
    chk("lat5_no_wr", 256'(b_wr_seen), 256'(0));

    // No HALT in a 4-entry program space: PC wraps and stays busy
    for (int i = 0; i < 4; i++) rom_b[i] = 9'b000_000_000;
    @(negedge clk);
    run_b(10, busy_n, done_n, done_at, fin);
    chk("wrap_still_busy", 256'({fin, busy_n, done_n}), 256'({1'b0, 32'd10, 32'd0}));
    chk("wrap_addr_seq", 256'({tr_iaddr[0], tr_iaddr[2], tr_iaddr[4], tr_iaddr[6], tr_iaddr[8]}),
        256'({8'd0, 8'd1, 8'd2, 8'd3, 8'd0}));
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("wrap_reset_idle", 256'({b_busy, b_iaddr}), 256'({1'b0, 2'd0}));

    chk("bus_invariants", 256'(viol), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
